rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
Round-robin arbiter that shares one 4:1 select datapath between four requesters (a, b, c, d).
- Drives the select pair s1/s0 and a one-hot grant vector.
- Routes the granted requester's data word to output f.
- Sits in front of the shared mux, so requesters never drive select lines directly.

Parameters:
WIDTH, 1, data width of each requester input and of f
HOLD_MAX, 8, max consecutive grant cycles per owner (used only with ARB_HOLD_LIMIT_EN), range 1..255

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req  input  4  request lines; bit0=a, bit1=b, bit2=c, bit3=d
a  input  WIDTH  requester 0 data
b  input  WIDTH  requester 1 data
c  input  WIDTH  requester 2 data
d  input  WIDTH  requester 3 data
gnt  output  4  one-hot grant, registered
s0  output  1  select LSB, registered
s1  output  1  select MSB, registered
busy  output  1  high while any grant is active, registered
f  output  WIDTH  shared data output

Behaviour:
- One clock (clk); reset rst is synchronous and active-high, sampled on the rising clk edge.
- Reset values: gnt=4'b0000, s1s0=2'b00, busy=0, priority pointer ptr=0 (a highest), state=IDLE. f reads 0 whenever busy=0.
- State machine has two states:
  - IDLE: no owner.
  - OWN: one owner; idx = {s1,s0}.
- IDLE, when req != 0: choose the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next edge: state=OWN, gnt=1<<idx, {s1,s0}=idx, busy=1.
  - Request-to-grant latency is exactly 1 cycle.
- IDLE, when req == 0: stay; outputs hold; s1/s0 keep their last value, with no toggling when idle.
- OWN, while req[idx]=1: grant holds. The owner keeps the resource indefinitely unless the optional feature is enabled.
- OWN, when req[idx]=0 is sampled: owner released; ptr <= idx+1 mod 4.
  - Same edge, if any other req bit is set: grant the next requester by round-robin from the new ptr. gnt changes one-hot to one-hot with no idle bubble; busy stays 1.
  - Same edge, if no req bit is set: state=IDLE, gnt=0, busy=0.
- Wrap-around: from ptr=3 (owner d released), scan order is a, b, c, d.
- gnt is always one-hot or zero. s1s0 equals the encoded gnt whenever busy=1.
- f is combinational: busy ? {a,b,c,d}[{s1,s0}] : 0. The owner's data change reaches f in the same cycle.
- A non-owner lowering req before being granted has no effect and is not remembered.
- A simultaneous release and re-request by the same owner in one cycle is treated as a release. Re-arbitration then places that owner last.
- Reset asserted mid-grant: next edge forces reset values. A pending request is re-arbitrated from ptr=0 on the first cycle after rst deasserts.

Optional Feature:
ARB_HOLD_LIMIT_EN
- Defined: an 8-bit hold counter clears on each new grant and increments every OWN cycle.
  - When the counter reaches HOLD_MAX-1 and req[idx] is still 1, the owner is force-released on the next edge, exactly as if req[idx] had dropped: ptr=idx+1, re-arbitrate.
  - A lone requester is regranted immediately and the counter restarts.
  - This bounds worst-case wait to 3*HOLD_MAX+3 cycles.
- Undefined: no counter; an owner holds while req[idx]=1.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, s1s0=00, busy=0, f=0. First grant after release is gnt=0001 one cycle later.
- Rotation: req=4'b1111, with each owner dropping its req for one cycle after a 3-cycle hold -> grant order a, b, c, d, a. s1s0 sequence 00, 01, 10, 11, 00. No idle cycle between grants.
- Data path: WIDTH=4, a=4'h3, b=4'h5, c=4'hA, d=4'hF, each granted in turn -> f=3, 5, A, F while its grant is active; f=0 when idle.
- Wrap/skip: ptr=2, req=4'b0011 -> gnt=0001 (a), not b. Then a releases -> gnt=0010.
- Reset mid-grant: d owns, assert rst for one cycle -> gnt=0, busy=0 on that edge. Then with req=1000 -> d regranted, s1s0=11 one cycle after rst low.
- Hold limit (ARB_HOLD_LIMIT_EN, HOLD_MAX=4): req=4'b0011 held continuously -> gnt alternates 0001, 0010 every 4 cycles. With req=4'b0001 only -> a regranted with no busy drop.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Round-robin arbiter in front of a shared 4:1 select datapath. Four
//   requesters (a, b, c, d) compete for the mux; the winner's select code
//   is driven on s1/s0, a one-hot grant is raised, and the winner's data
//   word is routed to f.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req[3:0]   request lines, bit0=a .. bit3=d
//   a,b,c,d    requester data words (WIDTH bits)
//   gnt[3:0]   one-hot grant (registered)
//   s1,s0      select code of the owner (registered, held while idle)
//   busy       high while a grant is active (registered)
//   f          owner's data when busy, else 0 (combinational)
//
// Optional build macro
//   ARB_HOLD_LIMIT_EN  bounds each ownership to HOLD_MAX cycles; after that
//                      the owner is released exactly as if its req dropped.
module rr_mux_arbiter #(
  parameter int WIDTH    = 1,
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [3:0]       gnt,
  output logic             s0,
  output logic             s1,
  output logic             busy,
  output logic [WIDTH-1:0] f
);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;

  // Arbitration result for the next edge
  logic [1:0] idx_d;
  logic       new_grant;
  logic       hold_exp;

`ifdef ARB_HOLD_LIMIT_EN
  logic [7:0] hold_q, hold_d;

  assign hold_exp = (hold_q == 8'(HOLD_MAX - 1));

  // Cleared on every new grant (including a lone owner being regranted),
  // counts each OWN cycle otherwise. It never passes HOLD_MAX-1 because
  // reaching it forces a release and therefore a new grant or IDLE.
  always_comb begin
    hold_d = hold_q;
    if (new_grant)
      hold_d = '0;
    else if (state_q == OWN)
      hold_d = hold_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`else
  assign hold_exp = 1'b0;
  // HOLD_MAX only matters with the hold limit built in.
  logic [7:0] unused_hold_max;
  assign unused_hold_max = 8'(HOLD_MAX);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: decide whether to arbitrate this edge and from which pointer.
  // On release the scan starts at owner+1, so a same-cycle re-request by the
  // old owner lands it last in the order.
  always_comb begin
    logic [1:0] scan_ptr;
    logic [1:0] j;
    logic [1:0] pick;
    logic       do_arb;

    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = sel_q;
    scan_ptr  = ptr_q;
    do_arb    = 1'b0;
    new_grant = 1'b0;
    j         = '0;
    pick      = '0;

    case (state_q)
      IDLE: do_arb = 1'b1;
      OWN: begin
        if (!req[sel_q] || hold_exp) begin
          ptr_d    = sel_q + 2'd1;
          scan_ptr = sel_q + 2'd1;
          do_arb   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Walk farthest-to-nearest so the nearest set bit from scan_ptr wins.
    for (int i = 3; i >= 0; i--) begin
      j = scan_ptr + 2'(i);
      if (req[j]) pick = j;
    end

    if (do_arb) begin
      if (|req) begin
        state_d   = OWN;
        idx_d     = pick;
        new_grant = 1'b1;
      end else begin
        state_d   = IDLE;
      end
    end
  end

  // Output decode for the registered outputs. Select lines hold their last
  // value while idle so the shared mux never toggles without an owner.
  always_comb begin
    gnt_d  = '0;
    busy_d = 1'b0;
    sel_d  = sel_q;
    if (state_d == OWN) begin
      gnt_d  = 4'b0001 << idx_d;
      busy_d = 1'b1;
      sel_d  = idx_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign s1   = sel_q[1];
  assign s0   = sel_q[0];

  // Shared datapath: owner's data passes straight through.
  always_comb begin
    f = '0;
    if (busy_q) begin
      case (sel_q)
        2'd0:    f = a;
        2'd1:    f = b;
        2'd2:    f = c;
        default: f = d;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [W-1:0] a, b, c, d;
  logic [3:0]   gnt;
  logic         s0, s1, busy;
  logic [W-1:0] f;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] dat [4];

  always #5 clk = ~clk;

  rr_mux_arbiter #(.WIDTH(W), .HOLD_MAX(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a(a), .b(b), .c(c), .d(d),
    .gnt(gnt), .s0(s0), .s1(s1), .busy(busy), .f(f)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_own(input string tag, input int k);
    chk({tag, "_gnt"},  32'(gnt), 32'(4'b0001 << k));
    chk({tag, "_sel"},  32'({s1, s0}), 32'(k));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_f"},    32'(f), 32'(dat[k]));
  endtask

  task automatic chk_idle(input string tag, input logic [1:0] sel);
    chk({tag, "_gnt"},  32'(gnt), 32'd0);
    chk({tag, "_sel"},  32'({s1, s0}), 32'(sel));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_f"},    32'(f), 32'd0);
  endtask

  initial begin
    dat[0] = 4'h3; dat[1] = 4'h5; dat[2] = 4'hA; dat[3] = 4'hF;
    a = dat[0]; b = dat[1]; c = dat[2]; d = dat[3];
    rst = 1'b1;
    req = 4'b1111;

    // Reset with all requesting
    tick(); tick();
    chk_idle("rst", 2'b00);
    rst = 1'b0;
    tick();
    chk_own("first", 0);

    // Rotation a,b,c,d,a; each owner holds 3 cycles then drops req once
    for (int k = 0; k < 4; k++) begin
      tick(); chk_own("hold1", k);
      tick(); chk_own("hold2", k);
      req = 4'b1111 & ~(4'b0001 << k);
      tick();
      chk_own("rot", (k + 1) % 4);
      req = 4'b1111;
    end

    // All drop: go idle, select held at 00
    req = 4'b0000;
    tick();
    chk_idle("idle", 2'b00);

    // Wrap/skip: b owns then releases with nobody waiting -> ptr=2
    req = 4'b0010;
    tick(); chk_own("b_own", 1);
    // Owner data change reaches f in the same cycle
    b = 4'h7; #1;
    chk("f_live", 32'(f), 32'h7);
    b = dat[1]; #1;
    req = 4'b0000;
    tick(); chk_idle("b_rel", 2'b01);
    req = 4'b0011;
    tick(); chk_own("wrap_a", 0);
    req = 4'b0010;
    tick(); chk_own("wrap_b", 1);

    // b releases, scan from c finds d
    req = 4'b1000;
    tick(); chk_own("d_own", 3);

    // Reset mid-grant, d re-requests after
    rst = 1'b1;
    tick(); chk_idle("mid_rst", 2'b00);
    rst = 1'b0;
    tick(); chk_own("d_regrant", 3);

    // Release and re-request in consecutive cycles: d goes last
    req = 4'b0111;
    tick(); chk_own("d_rel_a", 0);
    req = 4'b1110;
    tick(); chk_own("a_rel_b", 1);

`ifdef ARB_HOLD_LIMIT_EN
    req = 4'b0000;
    tick(); chk_idle("hl_idle", 2'b01);
    // ptr=2 now; scan c,d,a -> a first, then forced alternation every 4
    req = 4'b0011;
    tick();
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < 4; n++) begin
        chk_own("hl_alt", r % 2);
        tick();
      end
    end
    // Now a owns (after 4 forced swaps); lone requester keeps being regranted
    req = 4'b0001;
    for (int n = 0; n < 10; n++) begin
      chk_own("hl_lone", 0);
      tick();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stuck simulation
  initial begin
    #100000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1);
  end

endmodule
